// File: rtl/spi_peripheral_regfile_if.sv
// SPI pin bundle for the peripheral register file.
//   SCLK    : SPI clock from host, idle low (asynchronous to clk)
//   nCS     : chip select from host, active low (asynchronous to clk)
//   COPI    : data from host
//   CIPO    : data to host (registered in the peripheral)
//   cipo_oe : pad tristate enable, high while the peripheral is selected
interface spi_peripheral_regfile_if;
  logic SCLK;
  logic nCS;
  logic COPI;
  logic CIPO;
  logic cipo_oe;

  modport master (output SCLK, nCS, COPI, input CIPO, cipo_oe);
  modport slave  (input SCLK, nCS, COPI, output CIPO, cipo_oe);
endinterface

// File: rtl/spi_peripheral_regfile.sv
// SPI mode-0 peripheral giving a host write/read-back access to a bank of
// NUM_REGS registers of DATA_W bits. Frame is MSB first:
//   R/W (1 = write) | address (ADDR_W) | data (DATA_W)
// All SPI pins are oversampled through SYNC_STAGES flops (minimum 2).
// Ports:
//   clk, rst   : system clock (>= 8x SCLK), synchronous active-high reset
//   spi        : SPI pins (slave modport)
//   regs_out   : flattened bank, reg k at [k*DATA_W +: DATA_W]
//   wr_valid   : one-cycle pulse per committed write
//   wr_addr    : address of the committed write, valid with wr_valid
//   frame_err  : one-cycle pulse per rejected frame
module spi_peripheral_regfile #(
  parameter int NUM_REGS    = 5,
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  spi_peripheral_regfile_if.slave    spi,
  output logic [NUM_REGS*DATA_W-1:0] regs_out,
  output logic                       wr_valid,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic                       frame_err
);
  localparam int FRAME_W = 1 + ADDR_W + DATA_W;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  // Count value just before the rising edge that delivers the last address bit.
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(ADDR_W + 2);

  // Index 0 is the first (pin-side) stage, SYNC_STAGES-1 the oldest.
  logic [SYNC_STAGES-1:0] r_sclk_s, r_ncs_s, r_copi_s;

  logic [CNT_W-1:0]                r_cnt;
  logic [FRAME_W-1:0]              r_rx;
  logic [DATA_W-1:0]               r_tx;
  logic                            r_rw;
  logic                            r_cipo;
  logic                            r_wr_valid;
  logic [ADDR_W-1:0]               r_wr_addr;
  logic                            r_frame_err;
  logic [NUM_REGS-1:0][DATA_W-1:0] r_regs;

  logic               w_sclk, w_sclk_d, w_ncs, w_ncs_d, w_copi;
  logic               w_sclk_rise, w_sclk_fall, w_ncs_fall, w_ncs_rise, w_ncs_low;
  logic [FRAME_W-1:0] w_rx_next;
  logic [ADDR_W-1:0]  w_rd_addr, w_f_addr;
  logic [DATA_W-1:0]  w_rd_data, w_f_data;
  logic               w_f_in_range;

  // The newer of the last two stages is the synchronised level; comparing it
  // with the oldest stage gives a one-cycle edge strobe.
  assign w_sclk      = r_sclk_s[SYNC_STAGES-2];
  assign w_sclk_d    = r_sclk_s[SYNC_STAGES-1];
  assign w_ncs       = r_ncs_s[SYNC_STAGES-2];
  assign w_ncs_d     = r_ncs_s[SYNC_STAGES-1];
  assign w_copi      = r_copi_s[SYNC_STAGES-2];
  assign w_sclk_rise =  w_sclk & ~w_sclk_d;
  assign w_sclk_fall = ~w_sclk &  w_sclk_d;
  assign w_ncs_fall  = ~w_ncs  &  w_ncs_d;
  assign w_ncs_rise  =  w_ncs  & ~w_ncs_d;
  assign w_ncs_low   = ~w_ncs;

  assign w_rx_next = {r_rx[FRAME_W-2:0], w_copi};
  // Address as it completes on the current rising edge (read prefetch).
  assign w_rd_addr = w_rx_next[ADDR_W-1:0];
  // Fields of the fully received frame, used at commit time.
  assign w_f_addr  = r_rx[DATA_W +: ADDR_W];
  assign w_f_data  = r_rx[DATA_W-1:0];

  // Decoded read mux and range check; unimplemented addresses read as 0.
  always_comb begin
    w_rd_data    = '0;
    w_f_in_range = 1'b0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (w_rd_addr == ADDR_W'(k)) w_rd_data    = r_regs[k];
      if (w_f_addr  == ADDR_W'(k)) w_f_in_range = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_s    <= '0;
      r_ncs_s     <= '1;
      r_copi_s    <= '0;
      r_cnt       <= '0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_rw        <= 1'b0;
      r_cipo      <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= '0;
      r_frame_err <= 1'b0;
      r_regs      <= '0;
    end else begin
      r_sclk_s    <= {r_sclk_s[SYNC_STAGES-2:0], spi.SCLK};
      r_ncs_s     <= {r_ncs_s[SYNC_STAGES-2:0],  spi.nCS};
      r_copi_s    <= {r_copi_s[SYNC_STAGES-2:0], spi.COPI};
      r_wr_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      if (w_ncs_fall) begin
        r_cnt <= '0;
        r_rx  <= '0;
        r_tx  <= '0;
        r_rw  <= 1'b0;
      end else if (w_ncs_low) begin
        // Counter saturates at FRAME_W; extra edges are ignored.
        if (w_sclk_rise && r_cnt != CNT_FULL) begin
          r_cnt <= r_cnt + 1'b1;
          r_rx  <= w_rx_next;
          if (r_cnt == '0) r_rw <= w_copi;
          // Prefetch so the first data bit is on CIPO before the next rise.
          if (r_cnt == CNT_ADDR && !r_rw) r_tx <= w_rd_data;
        end
        if (w_sclk_fall && r_cnt >= CNT_DATA) r_tx <= {r_tx[DATA_W-2:0], 1'b0};
      end

      // Driven only during the data phase of a read, otherwise held at 0.
      r_cipo <= w_ncs_low & ~r_rw & (r_cnt > CNT_ADDR) & r_tx[DATA_W-1];

      if (w_ncs_rise) begin
        if (r_cnt == CNT_FULL && r_rw && w_f_in_range) begin
          for (int k = 0; k < NUM_REGS; k++)
            if (w_f_addr == ADDR_W'(k)) r_regs[k] <= w_f_data;
          r_wr_valid <= 1'b1;
          r_wr_addr  <= w_f_addr;
        end else if (!(r_cnt == CNT_FULL && !r_rw)) begin
          // Short frame or out-of-range write.
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  assign spi.CIPO    = r_cipo;
  assign spi.cipo_oe = w_ncs_low;
  assign regs_out    = r_regs;
  assign wr_valid    = r_wr_valid;
  assign wr_addr     = r_wr_addr;
  assign frame_err   = r_frame_err;
endmodule

// File: tb/tb_spi_peripheral_regfile.sv
module tb_spi_peripheral_regfile;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  spi_peripheral_regfile_if s0();
  spi_peripheral_regfile_if s1();

  logic [39:0]  regs0;
  logic [255:0] regs1;
  logic         wv0, wv1, fe0, fe1;
  logic [6:0]   wa0;
  logic [3:0]   wa1;

  spi_peripheral_regfile dut0 (
    .clk(clk), .rst(rst0), .spi(s0),
    .regs_out(regs0), .wr_valid(wv0), .wr_addr(wa0), .frame_err(fe0)
  );

  spi_peripheral_regfile #(
    .NUM_REGS(16), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(3)
  ) dut1 (
    .clk(clk), .rst(rst1), .spi(s1),
    .regs_out(regs1), .wr_valid(wv1), .wr_addr(wa1), .frame_err(fe1)
  );

  int total = 0;
  int bad   = 0;

  // Pulse monitors: every high cycle counts, so a stretched pulse shows up.
  int nwv[2]    = '{0, 0};
  int nfe[2]    = '{0, 0};
  int lastwa[2] = '{-1, -1};
  always @(posedge clk) begin
    if (wv0) begin nwv[0] <= nwv[0] + 1; lastwa[0] <= int'(wa0); end
    if (wv1) begin nwv[1] <= nwv[1] + 1; lastwa[1] <= int'(wa1); end
    if (fe0) nfe[0] <= nfe[0] + 1;
    if (fe1) nfe[1] <= nfe[1] + 1;
  end

  // Reference model: the register bank as plain values.
  logic [15:0] m[2][16];

  function automatic int nr(input int s); return (s != 0) ? 16 : 5; endfunction
  function automatic int aw(input int s); return (s != 0) ? 4  : 7; endfunction
  function automatic int dw(input int s); return (s != 0) ? 16 : 8; endfunction
  function automatic int fw(input int s); return 1 + aw(s) + dw(s); endfunction

  function automatic logic [15:0] get_reg(input int s, input int k);
    if (s != 0) return regs1[k*16 +: 16];
    return {8'h00, regs0[k*8 +: 8]};
  endfunction

  function automatic logic get_cipo(input int s);
    return (s != 0) ? s1.CIPO : s0.CIPO;
  endfunction

  function automatic logic [63:0] mk(input int s, input logic rw, input int addr, input logic [15:0] d);
    return (64'(rw) << (aw(s) + dw(s))) | (64'(addr) << dw(s)) | 64'(d);
  endfunction

  function automatic logic [63:0] dmask(input int s);
    return (64'd1 << dw(s)) - 64'd1;
  endfunction

  task automatic pins(input int s, input logic sc, input logic cs, input logic co);
    if (s != 0) begin s1.SCLK = sc; s1.nCS = cs; s1.COPI = co; end
    else        begin s0.SCLK = sc; s0.nCS = cs; s0.COPI = co; end
  endtask

  // Host side of one frame: n bits MSB first, SCLK half period of 8 clk.
  // CIPO is captured just before each rising SCLK, as a mode-0 host would.
  task automatic xfer(input int s, input logic [63:0] bits, input int n,
                      input bit raise, output logic [63:0] cap);
    cap = '0;
    pins(s, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      pins(s, 1'b0, 1'b0, bits[n-1-i]);
      repeat (8) @(negedge clk);
      cap = {cap[62:0], get_cipo(s)};
      pins(s, 1'b1, 1'b0, bits[n-1-i]);
      repeat (8) @(negedge clk);
    end
    pins(s, 1'b0, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    if (raise) begin
      pins(s, 1'b0, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1;
    repeat (4) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (4) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < nr(s); k++) begin
        total++;
        if (get_reg(s, k) !== 16'h0) begin
          bad++; $display("FAIL reset_reg s%0d r%0d: got %h want 0", s, k, get_reg(s, k));
        end
      end
    end
    total++;
    if ({s0.CIPO, s1.CIPO, s0.cipo_oe, s1.cipo_oe, wv0, wv1, fe0, fe1} !== 8'h00) begin
      bad++; $display("FAIL reset_outs: got %b want 00000000",
                      {s0.CIPO, s1.CIPO, s0.cipo_oe, s1.cipo_oe, wv0, wv1, fe0, fe1});
    end
  endtask

  task automatic test_write(input int s);
    logic [63:0] cap;
    logic [15:0] d = (s != 0) ? 16'h12A5 : 16'h00A5;
    int wv = nwv[s], fe = nfe[s];
    xfer(s, mk(s, 1'b1, 0, d), fw(s), 1'b1, cap);
    m[s][0] = d;
    for (int k = 0; k < nr(s); k++) begin
      total++;
      if (get_reg(s, k) !== m[s][k]) begin
        bad++; $display("FAIL write_bank s%0d r%0d: got %h want %h", s, k, get_reg(s, k), m[s][k]);
      end
    end
    total++;
    if (nwv[s] - wv !== 1 || lastwa[s] !== 0 || nfe[s] - fe !== 0 || cap !== 64'h0) begin
      bad++; $display("FAIL write_pulse s%0d: wv=%0d wa=%0d fe=%0d cap=%h want 1 0 0 0",
                      s, nwv[s] - wv, lastwa[s], nfe[s] - fe, cap);
    end
  endtask

  task automatic test_read(input int s);
    logic [63:0] cap;
    logic [15:0] d = (s != 0) ? 16'h8001 : 16'h0080;
    int wv, fe;
    xfer(s, mk(s, 1'b1, 4, d), fw(s), 1'b1, cap);
    m[s][4] = d;
    wv = nwv[s]; fe = nfe[s];
    xfer(s, mk(s, 1'b0, 4, 16'h0), fw(s), 1'b1, cap);
    total++;
    if ((cap & dmask(s)) !== 64'(m[s][4]) || (cap >> dw(s)) !== 64'h0) begin
      bad++; $display("FAIL read_cipo s%0d: got %h want %h", s, cap, 64'(m[s][4]));
    end
    total++;
    if (get_reg(s, 4) !== m[s][4] || nwv[s] - wv !== 0 || nfe[s] - fe !== 0) begin
      bad++; $display("FAIL read_side s%0d: reg4=%h wv=%0d fe=%0d want %h 0 0",
                      s, get_reg(s, 4), nwv[s] - wv, nfe[s] - fe, m[s][4]);
    end
  endtask

  task automatic test_short(input int s);
    logic [63:0] cap;
    int wv = nwv[s], fe = nfe[s];
    // Only the first 10 bits of a write frame, then nCS rises.
    xfer(s, mk(s, 1'b1, 2, 16'h00FF) >> (fw(s) - 10), 10, 1'b1, cap);
    for (int k = 0; k < nr(s); k++) begin
      total++;
      if (get_reg(s, k) !== m[s][k]) begin
        bad++; $display("FAIL short_bank s%0d r%0d: got %h want %h", s, k, get_reg(s, k), m[s][k]);
      end
    end
    total++;
    if (nfe[s] - fe !== 1 || nwv[s] - wv !== 0) begin
      bad++; $display("FAIL short_err s%0d: fe=%0d wv=%0d want 1 0", s, nfe[s] - fe, nwv[s] - wv);
    end
    xfer(s, mk(s, 1'b1, 1, 16'h003C), fw(s), 1'b1, cap);
    m[s][1] = 16'h003C;
    total++;
    if (get_reg(s, 1) !== 16'h003C || nwv[s] - wv !== 1 || lastwa[s] !== 1) begin
      bad++; $display("FAIL short_recover s%0d: reg1=%h wv=%0d wa=%0d want 003c 1 1",
                      s, get_reg(s, 1), nwv[s] - wv, lastwa[s]);
    end
  endtask

  task automatic test_oor(input int s);
    logic [63:0] cap;
    int wv = nwv[s], fe = nfe[s];
    xfer(s, mk(s, 1'b1, nr(s), 16'h00FF), fw(s), 1'b1, cap);
    for (int k = 0; k < nr(s); k++) begin
      total++;
      if (get_reg(s, k) !== m[s][k]) begin
        bad++; $display("FAIL oor_bank s%0d r%0d: got %h want %h", s, k, get_reg(s, k), m[s][k]);
      end
    end
    total++;
    if (nfe[s] - fe !== 1 || nwv[s] - wv !== 0) begin
      bad++; $display("FAIL oor_err s%0d: fe=%0d wv=%0d want 1 0", s, nfe[s] - fe, nwv[s] - wv);
    end
    xfer(s, mk(s, 1'b0, 9, 16'h0), fw(s), 1'b1, cap);
    total++;
    if (cap !== 64'h0 || nfe[s] - fe !== 1) begin
      bad++; $display("FAIL oor_read s%0d: cap=%h fe=%0d want 0 1", s, cap, nfe[s] - fe);
    end
  endtask

  task automatic test_rst_mid(input int s);
    logic [63:0] cap;
    logic [63:0] f = mk(s, 1'b1, 2, 16'h0077);
    int wv, fe;
    xfer(s, mk(s, 1'b1, 2, 16'h0055), fw(s), 1'b1, cap);
    m[s][2] = 16'h0055;
    total++;
    if (get_reg(s, 2) !== 16'h0055) begin
      bad++; $display("FAIL rstmid_pre s%0d: got %h want 0055", s, get_reg(s, 2));
    end
    xfer(s, f >> (fw(s) - 8), 8, 1'b0, cap);
    if (s != 0) rst1 = 1'b1; else rst0 = 1'b1;
    repeat (4) @(negedge clk);
    for (int k = 0; k < 16; k++) m[s][k] = 16'h0;
    for (int k = 0; k < nr(s); k++) begin
      total++;
      if (get_reg(s, k) !== 16'h0) begin
        bad++; $display("FAIL rstmid_bank s%0d r%0d: got %h want 0", s, k, get_reg(s, k));
      end
    end
    total++;
    if (get_cipo(s) !== 1'b0) begin
      bad++; $display("FAIL rstmid_cipo s%0d: got %b want 0", s, get_cipo(s));
    end
    if (s != 0) rst1 = 1'b0; else rst0 = 1'b0;
    wv = nwv[s]; fe = nfe[s];
    xfer(s, f & 64'hFF, 8, 1'b1, cap);
    total++;
    if (nfe[s] - fe !== 1 || nwv[s] - wv !== 0 || get_reg(s, 2) !== 16'h0) begin
      bad++; $display("FAIL rstmid_tail s%0d: fe=%0d wv=%0d reg2=%h want 1 0 0",
                      s, nfe[s] - fe, nwv[s] - wv, get_reg(s, 2));
    end
  endtask

  task automatic test_wide();
    logic [63:0] cap;
    xfer(1, mk(1, 1'b1, 15, 16'hBEEF), fw(1), 1'b1, cap);
    m[1][15] = 16'hBEEF;
    total++;
    if (regs1[255:240] !== 16'hBEEF || lastwa[1] !== 15) begin
      bad++; $display("FAIL wide_write: got %h wa=%0d want beef 15", regs1[255:240], lastwa[1]);
    end
    xfer(1, mk(1, 1'b0, 15, 16'h0), fw(1), 1'b1, cap);
    total++;
    if (cap !== 64'hBEEF) begin
      bad++; $display("FAIL wide_read: got %h want beef", cap);
    end
  endtask

  task automatic test_random(input int s, input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [63:0] cap;
      int amax = (nr(s) + 2 < (1 << aw(s))) ? nr(s) + 2 : (1 << aw(s)) - 1;
      logic rw = 1'($urandom_range(0, 1));
      int addr = int'($urandom_range(0, amax));
      logic [15:0] d = 16'($urandom) & 16'(dmask(s));
      int n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, fw(s) - 1)) : fw(s);
      int wv = nwv[s], fe = nfe[s];
      bit full = (n == fw(s));
      bit wr_ok = full && rw && addr < nr(s);
      int exp_fe = (!full || (rw && addr >= nr(s))) ? 1 : 0;
      logic [15:0] exp_rd = (addr < nr(s)) ? m[s][addr] : 16'h0;
      xfer(s, mk(s, rw, addr, d) >> (fw(s) - n), n, 1'b1, cap);
      if (wr_ok) m[s][addr] = d;
      total++;
      if (nwv[s] - wv !== (wr_ok ? 1 : 0) || nfe[s] - fe !== exp_fe ||
          (wr_ok && lastwa[s] !== addr)) begin
        bad++; $display("FAIL rand_pulse s%0d it%0d: wv=%0d fe=%0d wa=%0d want %0d %0d %0d",
                        s, it, nwv[s] - wv, nfe[s] - fe, lastwa[s], wr_ok ? 1 : 0, exp_fe, addr);
      end
      if (full && !rw) begin
        total++;
        if (cap !== 64'(exp_rd)) begin
          bad++; $display("FAIL rand_read s%0d it%0d a%0d: got %h want %h", s, it, addr, cap, exp_rd);
        end
      end
      if (rw) begin
        total++;
        if (cap !== 64'h0) begin
          bad++; $display("FAIL rand_cipo_idle s%0d it%0d: got %h want 0", s, it, cap);
        end
      end
      for (int k = 0; k < nr(s); k++) begin
        total++;
        if (get_reg(s, k) !== m[s][k]) begin
          bad++; $display("FAIL rand_bank s%0d it%0d r%0d: got %h want %h", s, it, k, get_reg(s, k), m[s][k]);
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < 16; k++) m[s][k] = 16'h0;
    pins(0, 1'b0, 1'b1, 1'b0);
    pins(1, 1'b0, 1'b1, 1'b0);
    rst0 = 1'b1; rst1 = 1'b1;
    test_reset();
    for (int s = 0; s < 2; s++) begin
      test_write(s);
      test_read(s);
      test_short(s);
      test_random(s, 20);
    end
    test_oor(0);
    test_rst_mid(0);
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
